bus_dpram_pipelined: RTL and testbench

Parametrised successor to the team's bus-attached dual-port RAM. Port A is tied to the 16-bit bus; Port B is a general-purpose word port. Over the single-cycle version it adds a selectable read latency (1 or 2 cycles), out-of-range address handling, Port B read strobe with data-valid, and a sticky write-collision detector. It sits on the bus as a shared buffer between bus masters and local datapath logic.

---
 rtl/bus_dpram_pipelined.sv | 133 +++++++++++++
 tb/tb_bus_dpram_pipelined.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_dpram_pipelined.sv
// Dual-port 16-bit RAM shared between a bus master (Port A) and a local word
// port (Port B). Read latency is 1 or 2 cycles, and both ports are read-first.
// A bus access outside DEPTH is dropped on write and returns OOR_DATA on read.
// A sticky flag records when both ports write the same word in the same cycle.
//
// Ports:
//   i_Bus_Clk, i_Bus_Rst_L        - clock, synchronous active-low reset
//   i_Bus_CS, i_Bus_Wr_Rd_n       - bus strobe and direction (1 = write)
//   i_Bus_Addr8, i_Bus_Wr_Data    - bus byte address and write data
//   o_Bus_Rd_Data, o_Bus_Rd_DV    - bus read data and its valid pulse
//   i_PortB_Data, i_PortB_Addr16  - Port B write data and word address
//   i_PortB_WE, i_PortB_RE        - Port B write and read enables
//   o_PortB_Data, o_PortB_DV      - Port B read data and its valid pulse
//   o_Collision, i_Collision_Clr  - sticky write-collision flag and its clear
module bus_dpram_pipelined #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [15:0] OOR_DATA   = 16'hBAD0
) (
   input  logic                       i_Bus_Clk,
   input  logic                       i_Bus_Rst_L,
   input  logic                       i_Bus_CS,
   input  logic                       i_Bus_Wr_Rd_n,
   input  logic [15:0]                i_Bus_Addr8,
   input  logic [15:0]                i_Bus_Wr_Data,
   output logic [15:0]                o_Bus_Rd_Data,
   output logic                       o_Bus_Rd_DV,
   input  logic [15:0]                i_PortB_Data,
   input  logic [$clog2(DEPTH)-1:0]   i_PortB_Addr16,
   input  logic                       i_PortB_WE,
   input  logic                       i_PortB_RE,
   output logic [15:0]                o_PortB_Data,
   output logic                       o_PortB_DV,
   output logic                       o_Collision,
   input  logic                       i_Collision_Clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = 16;

   logic [DW-1:0] mem [DEPTH];

   // Bus address decode. The word address is Addr8[15:1]; bit 0 is not used.
   logic [14:0]   bus_word_c;
   logic [AW-1:0] bus_idx_c;
   logic          bus_in_range_c;
   logic          bus_wr_c;
   logic          bus_rd_c;
   logic          collision_c;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = i_Bus_Addr8[0];
   assign bus_word_c      = i_Bus_Addr8[15:1];
   assign bus_idx_c       = bus_word_c[AW-1:0];
   assign bus_in_range_c  = 32'(bus_word_c) < DEPTH;
   assign bus_wr_c        = i_Bus_CS & i_Bus_Wr_Rd_n & bus_in_range_c;
   assign bus_rd_c        = i_Bus_CS & ~i_Bus_Wr_Rd_n;
   assign collision_c     = bus_wr_c & i_PortB_WE & (bus_idx_c == i_PortB_Addr16);

   // RAM write. On a collision Port B is suppressed, so the bus data is stored.
   // There is no reset on the array, so its contents survive a reset.
   always_ff @(posedge i_Bus_Clk) begin
      if (i_PortB_WE && !collision_c) mem[i_PortB_Addr16] <= i_PortB_Data;
      if (bus_wr_c)                   mem[bus_idx_c]      <= i_Bus_Wr_Data;
   end

   // First read stage. The out-of-range substitution is resolved at issue.
   // Non-blocking RAM semantics make every read return the pre-write contents.
   logic [DW-1:0] bus_s1_data_d, bus_s1_data_q;
   logic [DW-1:0] pb_s1_data_d,  pb_s1_data_q;
   logic          bus_s1_dv_q,   pb_s1_dv_q;
   logic          collision_d,   collision_q;

   always_comb begin
      bus_s1_data_d = bus_s1_data_q;
      pb_s1_data_d  = pb_s1_data_q;
      collision_d   = collision_q;
      if (bus_rd_c)         bus_s1_data_d = bus_in_range_c ? mem[bus_idx_c] : OOR_DATA;
      if (i_PortB_RE)       pb_s1_data_d  = mem[i_PortB_Addr16];
      if (collision_c)      collision_d   = 1'b1;
      else if (i_Collision_Clr) collision_d = 1'b0;
   end

   always_ff @(posedge i_Bus_Clk) begin
      if (!i_Bus_Rst_L) begin
         bus_s1_data_q <= '0;
         pb_s1_data_q  <= '0;
         bus_s1_dv_q   <= 1'b0;
         pb_s1_dv_q    <= 1'b0;
         collision_q   <= 1'b0;
      end else begin
         bus_s1_data_q <= bus_s1_data_d;
         pb_s1_data_q  <= pb_s1_data_d;
         bus_s1_dv_q   <= bus_rd_c;
         pb_s1_dv_q    <= i_PortB_RE;
         collision_q   <= collision_d;
      end
   end

   assign o_Collision = collision_q;

   // Optional second output register. Data advances only on a valid beat so
   // that the outputs hold their last read value between DV pulses.
   if (RD_LATENCY == 2) begin : g_lat2
      logic [DW-1:0] bus_s2_data_q, pb_s2_data_q;
      logic          bus_s2_dv_q,   pb_s2_dv_q;

      always_ff @(posedge i_Bus_Clk) begin
         if (!i_Bus_Rst_L) begin
            bus_s2_data_q <= '0;
            pb_s2_data_q  <= '0;
            bus_s2_dv_q   <= 1'b0;
            pb_s2_dv_q    <= 1'b0;
         end else begin
            bus_s2_dv_q <= bus_s1_dv_q;
            pb_s2_dv_q  <= pb_s1_dv_q;
            if (bus_s1_dv_q) bus_s2_data_q <= bus_s1_data_q;
            if (pb_s1_dv_q)  pb_s2_data_q  <= pb_s1_data_q;
         end
      end

      assign o_Bus_Rd_Data = bus_s2_data_q;
      assign o_Bus_Rd_DV   = bus_s2_dv_q;
      assign o_PortB_Data  = pb_s2_data_q;
      assign o_PortB_DV    = pb_s2_dv_q;
   end else begin : g_lat1
      assign o_Bus_Rd_Data = bus_s1_data_q;
      assign o_Bus_Rd_DV   = bus_s1_dv_q;
      assign o_PortB_Data  = pb_s1_data_q;
      assign o_PortB_DV    = pb_s1_dv_q;
   end

endmodule

// File: tb/tb_bus_dpram_pipelined.sv
// Directed bench driving two instances with shared stimulus:
//   u_dut_a: DEPTH=256, RD_LATENCY=1
//   u_dut_b: DEPTH=64,  RD_LATENCY=2
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_bus_dpram_pipelined;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs, wr;
   logic [15:0] addr8, wdata, pb_data;
   logic [7:0]  pb_addr;
   logic        pb_we, pb_re, clr;

   logic [15:0] a_rd, a_pbd, b_rd, b_pbd;
   logic        a_dv, a_pbdv, a_col, b_dv, b_pbdv, b_col;

   int checks   = 0;
   int failures = 0;

   logic [15:0] pre [4] = '{16'h0000, 16'h0011, 16'h0022, 16'h0033};

   always #5 clk = ~clk;

   bus_dpram_pipelined #(.DEPTH(256), .RD_LATENCY(1), .OOR_DATA(16'hBAD0)) u_dut_a (
      .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .i_Bus_CS(cs), .i_Bus_Wr_Rd_n(wr),
      .i_Bus_Addr8(addr8), .i_Bus_Wr_Data(wdata), .o_Bus_Rd_Data(a_rd), .o_Bus_Rd_DV(a_dv),
      .i_PortB_Data(pb_data), .i_PortB_Addr16(pb_addr), .i_PortB_WE(pb_we),
      .i_PortB_RE(pb_re), .o_PortB_Data(a_pbd), .o_PortB_DV(a_pbdv),
      .o_Collision(a_col), .i_Collision_Clr(clr));

   bus_dpram_pipelined #(.DEPTH(64), .RD_LATENCY(2), .OOR_DATA(16'hBAD0)) u_dut_b (
      .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .i_Bus_CS(cs), .i_Bus_Wr_Rd_n(wr),
      .i_Bus_Addr8(addr8), .i_Bus_Wr_Data(wdata), .o_Bus_Rd_Data(b_rd), .o_Bus_Rd_DV(b_dv),
      .i_PortB_Data(pb_data), .i_PortB_Addr16(pb_addr[5:0]), .i_PortB_WE(pb_we),
      .i_PortB_RE(pb_re), .o_PortB_Data(b_pbd), .o_PortB_DV(b_pbdv),
      .o_Collision(b_col), .i_Collision_Clr(clr));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs = 1'b0; wr = 1'b0; pb_we = 1'b0; pb_re = 1'b0; clr = 1'b0;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      cs = 1'b1; wr = 1'b1; addr8 = a; wdata = d;
      tick();
      idle();
   endtask

   initial begin
      rst_n = 1'b0; addr8 = '0; wdata = '0; pb_data = '0; pb_addr = '0;
      idle();
      repeat (3) tick();

      // Reset state
      check_eq("rst_a_dv",   32'(a_dv),   0);
      check_eq("rst_a_rd",   32'(a_rd),   0);
      check_eq("rst_b_pbdv", 32'(b_pbdv), 0);
      check_eq("rst_b_pbd",  32'(b_pbd),  0);
      check_eq("rst_col",    32'({a_col, b_col}), 0);
      rst_n = 1'b1;
      tick();

      // Preload words 0..3
      for (int i = 0; i < 4; i++) bus_write(16'(2 * i), pre[i]);

      // Bus write at byte 0x10 -> Port B read of word 8
      bus_write(16'h0010, 16'h1234);
      pb_re = 1'b1; pb_addr = 8'd8;
      tick();
      idle();
      check_eq("pb8_a_dv",   32'(a_pbdv), 1);
      check_eq("pb8_a_data", 32'(a_pbd),  32'h1234);
      check_eq("pb8_b_dv_early", 32'(b_pbdv), 0);
      tick();
      check_eq("pb8_b_dv",   32'(b_pbdv), 1);
      check_eq("pb8_b_data", 32'(b_pbd),  32'h1234);
      check_eq("pb8_a_dv_pulse", 32'(a_pbdv), 0);

      // Four back-to-back bus reads of words 0..3
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            cs = 1'b1; wr = 1'b0; addr8 = 16'(2 * i);
         end else begin
            idle();
         end
         tick();
         check_eq($sformatf("b2b_a_dv%0d", i), 32'(a_dv), (i < 4) ? 1 : 0);
         if (i < 4) check_eq($sformatf("b2b_a_data%0d", i), 32'(a_rd), 32'(pre[i]));
         check_eq($sformatf("b2b_b_dv%0d", i), 32'(b_dv), (i >= 1) ? 1 : 0);
         if (i >= 1) check_eq($sformatf("b2b_b_data%0d", i), 32'(b_rd), 32'(pre[i-1]));
      end
      tick();
      check_eq("b2b_b_dv_end", 32'(b_dv), 0);
      check_eq("b2b_b_hold",   32'(b_rd), 32'h0033);

      // Port B write word 3 -> bus read at byte 0x0007
      pb_we = 1'b1; pb_addr = 8'd3; pb_data = 16'hA5A5;
      tick();
      idle();
      cs = 1'b1; wr = 1'b0; addr8 = 16'h0007;
      tick();
      idle();
      check_eq("w3_a_dv",   32'(a_dv), 1);
      check_eq("w3_a_data", 32'(a_rd), 32'hA5A5);
      tick();
      check_eq("w3_b_dv",   32'(b_dv), 1);
      check_eq("w3_b_data", 32'(b_rd), 32'hA5A5);

      // Byte 0x0080 is word 64: in range for u_dut_a, out of range for u_dut_b
      bus_write(16'h0080, 16'hFFFF);
      pb_re = 1'b1; pb_addr = 8'd0;
      tick();
      idle();
      check_eq("oor_a_word0", 32'(a_pbd), 32'h0000);
      tick();
      check_eq("oor_b_word0_dv", 32'(b_pbdv), 1);
      check_eq("oor_b_word0",    32'(b_pbd),  32'h0000);
      cs = 1'b1; wr = 1'b0; addr8 = 16'h0080;
      tick();
      idle();
      check_eq("oor_a_dv",   32'(a_dv), 1);
      check_eq("oor_a_data", 32'(a_rd), 32'hFFFF);
      tick();
      check_eq("oor_b_dv",   32'(b_dv), 1);
      check_eq("oor_b_data", 32'(b_rd), 32'hBAD0);

      // Write collision on word 5
      cs = 1'b1; wr = 1'b1; addr8 = 16'h000A; wdata = 16'h1111;
      pb_we = 1'b1; pb_addr = 8'd5; pb_data = 16'h2222;
      tick();
      idle();
      check_eq("col_a_set", 32'(a_col), 1);
      check_eq("col_b_set", 32'(b_col), 1);
      pb_re = 1'b1; pb_addr = 8'd5;
      tick();
      idle();
      check_eq("col_a_word5", 32'(a_pbd), 32'h1111);
      check_eq("col_sticky",  32'({a_col, b_col}), 32'h3);
      tick();
      check_eq("col_b_word5", 32'(b_pbd), 32'h1111);
      clr = 1'b1;
      tick();
      idle();
      check_eq("col_clr", 32'({a_col, b_col}), 0);
      cs = 1'b1; wr = 1'b1; addr8 = 16'h000A; wdata = 16'h1111;
      pb_we = 1'b1; pb_addr = 8'd5; pb_data = 16'h2222; clr = 1'b1;
      tick();
      idle();
      check_eq("col_set_wins", 32'({a_col, b_col}), 32'h3);

      // Reset asserted one cycle after a bus read issue
      cs = 1'b1; wr = 1'b0; addr8 = 16'h0006;
      tick();
      idle();
      rst_n = 1'b0;
      check_eq("rstf_a_dv",   32'(a_dv), 1);
      check_eq("rstf_a_data", 32'(a_rd), 32'hA5A5);
      tick();
      check_eq("rstf_b_dv",   32'(b_dv),   0);
      check_eq("rstf_b_rd",   32'(b_rd),   0);
      check_eq("rstf_b_pbd",  32'(b_pbd),  0);
      check_eq("rstf_a_rd",   32'(a_rd),   0);
      check_eq("rstf_col",    32'({a_col, b_col}), 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("rstf_b_no_dv%0d", i), 32'(b_dv), 0);
      end

      // RAM contents survive reset
      cs = 1'b1; wr = 1'b0; addr8 = 16'h000A;
      tick();
      idle();
      check_eq("post_a_dv",   32'(a_dv), 1);
      check_eq("post_a_data", 32'(a_rd), 32'h1111);
      tick();
      check_eq("post_b_dv",   32'(b_dv), 1);
      check_eq("post_b_data", 32'(b_rd), 32'h1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
